// File: rtl/rect_draw_control.sv
// Rectangle draw controller: three button-stepped load phases (corner A,
// corner B, colour/mode), then a row-major pixel scan of the normalised
// rectangle, optionally plotting only its outline.
module rect_draw_control #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                mode,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  output logic                ld_a,
  output logic                ld_b,
  output logic                ld_c,
  output logic                busy,
  output logic                done
);

  typedef enum logic [3:0] {
    S_LOAD_A      = 4'd0,
    S_LOAD_A_WAIT = 4'd1,
    S_LOAD_B      = 4'd2,
    S_LOAD_B_WAIT = 4'd3,
    S_LOAD_C      = 4'd4,
    S_LOAD_C_WAIT = 4'd5,
    S_DRAW        = 4'd6,
    S_DONE        = 4'd7,
    S_DONE_WAIT   = 4'd8
  } state_t;

  state_t state_q, state_d;

  logic [X_W-1:0]      ax_q, ax_d, bx_q, bx_d;
  logic [Y_W-1:0]      ay_q, ay_d, by_q, by_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                mode_q, mode_d;
  logic [X_W-1:0]      xmin_q, xmin_d, xmax_q, xmax_d, x_q, x_d;
  logic [Y_W-1:0]      ymin_q, ymin_d, ymax_q, ymax_d, y_q, y_d;

  logic x_end, y_end, on_edge;

  // Scan terminates on equality with the bound, so a bound at the top of
  // the coordinate range never needs a wrapping increment.
  assign x_end   = (x_q == xmax_q);
  assign y_end   = (y_q == ymax_q);
  assign on_edge = (x_q == xmin_q) || x_end || (y_q == ymin_q) || y_end;

  // Next-state and state-decoded outputs; unknown encodings recover to LOAD_A.
  always_comb begin
    state_d = state_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_c    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    plot    = 1'b0;
    case (state_q)
      S_LOAD_A: begin
        ld_a = 1'b1;
        if (go) state_d = S_LOAD_A_WAIT;
      end
      S_LOAD_A_WAIT: if (!go) state_d = S_LOAD_B;
      S_LOAD_B: begin
        ld_b = 1'b1;
        if (go) state_d = S_LOAD_B_WAIT;
      end
      S_LOAD_B_WAIT: if (!go) state_d = S_LOAD_C;
      S_LOAD_C: begin
        ld_c = 1'b1;
        if (go) state_d = S_LOAD_C_WAIT;
      end
      S_LOAD_C_WAIT: if (!go) state_d = S_DRAW;
      S_DRAW: begin
        busy = 1'b1;
        plot = !mode_q || on_edge;
        if (x_end && y_end) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (go) state_d = S_DONE_WAIT;
      end
      S_DONE_WAIT: begin
        done = 1'b1;
        if (!go) state_d = S_LOAD_A;
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  // Datapath: operand capture, bound normalisation on DRAW entry, pixel stepping.
  always_comb begin
    ax_d     = ax_q;
    ay_d     = ay_q;
    bx_d     = bx_q;
    by_d     = by_q;
    colour_d = colour_q;
    mode_d   = mode_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymin_d   = ymin_q;
    ymax_d   = ymax_q;
    x_d      = x_q;
    y_d      = y_q;
    case (state_q)
      S_LOAD_A: begin
        ax_d = x_in;
        ay_d = y_in;
      end
      S_LOAD_B: begin
        bx_d = x_in;
        by_d = y_in;
      end
      S_LOAD_C: begin
        colour_d = colour_in;
        mode_d   = mode;
      end
      S_LOAD_C_WAIT: begin
        if (!go) begin
          xmin_d = (ax_q < bx_q) ? ax_q : bx_q;
          xmax_d = (ax_q < bx_q) ? bx_q : ax_q;
          ymin_d = (ay_q < by_q) ? ay_q : by_q;
          ymax_d = (ay_q < by_q) ? by_q : ay_q;
          x_d    = xmin_d;
          y_d    = ymin_d;
        end
      end
      S_DRAW: begin
        if (!x_end) begin
          x_d = x_q + 1'b1;
        end else if (!y_end) begin
          x_d = xmin_q;
          y_d = y_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LOAD_A;
      ax_q     <= '0;
      ay_q     <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      colour_q <= '0;
      mode_q   <= 1'b0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      colour_q <= colour_d;
      mode_q   <= mode_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = colour_q;

endmodule

// File: tb/tb_rect_draw_control.sv
// Bench for rect_draw_control: directed rectangles plus randomised ones,
// each pixel compared against a nested-loop reference scan.
module tb_rect_draw_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic       mode;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot, ld_a, ld_b, ld_c, busy, done;

  int checks   = 0;
  int failures = 0;

  rect_draw_control #(.X_W(8), .Y_W(7), .COLOUR_W(3)) dut (
    .clk(clk), .reset(reset), .go(go), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .mode(mode), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot), .ld_a(ld_a), .ld_b(ld_b),
    .ld_c(ld_c), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected.
  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // go_mode: 0 = go low during DRAW, 1 = random, 2 = held high.
  // abort_at >= 0 pulses reset during that DRAW cycle index.
  task automatic draw_rect(input int ax, input int ay, input int bx, input int by,
                           input int col, input int md, input int go_mode, input int abort_at);
    int xmin, xmax, ymin, ymax, k, w, h, plot_cnt, exp_cnt, iw, ih;
    bit ep;
    xmin = (ax < bx) ? ax : bx;
    xmax = (ax < bx) ? bx : ax;
    ymin = (ay < by) ? ay : by;
    ymax = (ay < by) ? by : ay;
    w = xmax - xmin + 1;
    h = ymax - ymin + 1;
    iw = (w > 2) ? w - 2 : 0;
    ih = (h > 2) ? h - 2 : 0;
    exp_cnt = (md != 0) ? (w * h - iw * ih) : (w * h);

    check_value("ld_a_idle", 32'(ld_a), 1);
    x_in = 8'(ax); y_in = 7'(ay); go = 1'b1;
    tick();
    check_value("ld_a_wait", 32'(ld_a), 0);
    go = 1'b0; x_in = 8'($urandom); y_in = 7'($urandom);
    tick();
    check_value("ld_b", 32'(ld_b), 1);
    x_in = 8'(bx); y_in = 7'(by); go = 1'b1;
    tick();
    go = 1'b0; x_in = 8'($urandom); y_in = 7'($urandom);
    tick();
    check_value("ld_c", 32'(ld_c), 1);
    colour_in = 3'(col); mode = md[0]; go = 1'b1;
    tick();
    go = 1'b0; colour_in = 3'($urandom); mode = 1'($urandom);
    tick();

    k = 0;
    plot_cnt = 0;
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x++) begin
        ep = (md == 0) || (x == xmin) || (x == xmax) || (y == ymin) || (y == ymax);
        check_value("draw_busy", 32'(busy), 1);
        check_value("draw_x", 32'(x_out), x);
        check_value("draw_y", 32'(y_out), y);
        check_value("draw_plot", 32'(plot), 32'(ep));
        check_value("draw_colour", 32'(colour_out), col);
        if (plot === 1'b1) plot_cnt++;
        if (k == abort_at) begin
          reset = 1'b1; go = 1'b0;
          tick();
          reset = 1'b0;
          check_value("abort_ld_a", 32'(ld_a), 1);
          check_value("abort_busy", 32'(busy), 0);
          check_value("abort_x", 32'(x_out), 0);
          check_value("abort_y", 32'(y_out), 0);
          check_value("abort_colour", 32'(colour_out), 0);
          for (int i = 0; i < 5; i++) begin
            check_value("abort_plot", 32'(plot), 0);
            tick();
          end
          $display("rect A=(%0d,%0d) B=(%0d,%0d) aborted at draw cycle %0d", ax, ay, bx, by, k);
          return;
        end
        case (go_mode)
          1: go = 1'($urandom);
          2: go = 1'b1;
          default: go = 1'b0;
        endcase
        k++;
        tick();
      end
    end
    check_value("plot_count", plot_cnt, exp_cnt);
    check_value("done", 32'(done), 1);
    check_value("done_busy", 32'(busy), 0);
    check_value("done_plot", 32'(plot), 0);
    check_value("done_x", 32'(x_out), xmax);
    check_value("done_y", 32'(y_out), ymax);
    check_value("done_colour", 32'(colour_out), col);
    go = 1'b1;
    tick();
    check_value("done_wait", 32'(done), 1);
    go = 1'b0;
    tick();
    check_value("back_ld_a", 32'(ld_a), 1);
    check_value("back_done", 32'(done), 0);
    $display("rect A=(%0d,%0d) B=(%0d,%0d) col=%0d mode=%0d cycles=%0d plots=%0d",
             ax, ay, bx, by, col, md, k, plot_cnt);
  endtask

  initial begin
    int x0, y0, x1, y1, w, h;
    reset = 1'b1; go = 1'b0; x_in = '0; y_in = '0; colour_in = '0; mode = 1'b0;
    tick();
    tick();
    check_value("rst_ld_a", 32'(ld_a), 1);
    check_value("rst_x", 32'(x_out), 0);
    check_value("rst_y", 32'(y_out), 0);
    check_value("rst_colour", 32'(colour_out), 0);
    check_value("rst_plot", 32'(plot), 0);
    check_value("rst_busy", 32'(busy), 0);
    check_value("rst_done", 32'(done), 0);
    reset = 1'b0;

    draw_rect(2, 3, 5, 4, 5, 0, 0, -1);
    draw_rect(5, 4, 2, 3, 5, 0, 1, -1);
    draw_rect(0, 0, 3, 3, 6, 1, 1, -1);
    draw_rect(7, 7, 7, 7, 2, 0, 1, -1);
    draw_rect(7, 7, 7, 7, 3, 1, 0, -1);
    draw_rect(254, 126, 255, 127, 1, 0, 1, -1);
    draw_rect(255, 127, 254, 126, 4, 1, 1, -1);
    draw_rect(10, 20, 10, 25, 7, 1, 1, -1);
    draw_rect(2, 3, 5, 4, 5, 0, 2, 2);
    draw_rect(2, 3, 5, 4, 5, 0, 0, -1);

    for (int i = 0; i < 20; i++) begin
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 6);
      if (i % 4 == 0) begin
        x0 = 256 - w;
        y0 = 128 - h;
      end else begin
        x0 = $urandom_range(0, 256 - w);
        y0 = $urandom_range(0, 128 - h);
      end
      x1 = x0 + w - 1;
      y1 = y0 + h - 1;
      if ($urandom_range(0, 1) == 1)
        draw_rect(x1, y1, x0, y0, $urandom_range(0, 7), $urandom_range(0, 1), 1, -1);
      else
        draw_rect(x0, y1, x1, y0, $urandom_range(0, 7), $urandom_range(0, 1), 1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
